// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control stage for the WISC datapath.
// Decodes ALUOp/ALUF into ALU control, holds it in a one-entry output
// register with valid/ready flow control, and sequences iterative
// multiply/divide ops by strobing md_step for ITER_CYCLES cycles before
// presenting the result control.
module alu_ctrl_seq #(
    parameter int unsigned ITER_CYCLES = 16,
    parameter logic [4:0]  MUL_OP      = 5'b00010,
    parameter logic [4:0]  DIV_OP      = 5'b00011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] ALUOp,
    input  logic [1:0] ALUF,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] opOut,
    output logic       invB,
    output logic       immPass,
    output logic [5:0] spec_op,
    output logic       illegal,
    output logic       md_step,
    output logic       md_first,
    output logic       md_div
);

    localparam int unsigned CW = $clog2(ITER_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_ITER = 2'b10
    } state_t;

    // spec_op one-hot bit positions {SLT,SLE,SEQ,SCO,BTR,SLBI}
    localparam logic [5:0] SPEC_SLT  = 6'b100000;
    localparam logic [5:0] SPEC_SLE  = 6'b010000;
    localparam logic [5:0] SPEC_SEQ  = 6'b001000;
    localparam logic [5:0] SPEC_SCO  = 6'b000100;
    localparam logic [5:0] SPEC_BTR  = 6'b000010;
    localparam logic [5:0] SPEC_SLBI = 6'b000001;

    // ALU operation codes
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_ANDN = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    // decoder outputs
    logic [3:0] dec_op;
    logic       dec_invb;
    logic       dec_imm;
    logic [5:0] dec_spec;
    logic       dec_ill;
    logic       dec_is_md;
    logic       dec_is_div;

    // state and registered outputs
    state_t          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      op_q,        op_d;
    logic            invb_q,      invb_d;
    logic            imm_q,       imm_d;
    logic [5:0]      spec_q,      spec_d;
    logic            ill_q,       ill_d;
    logic            md_step_q,   md_step_d;
    logic            md_first_q,  md_first_d;
    logic            md_div_q,    md_div_d;

    logic            accept;

    // Decode the presented opcode/function into ALU control fields
    always_comb begin
        dec_op     = OP_BAD;
        dec_invb   = 1'b0;
        dec_imm    = 1'b0;
        dec_spec   = '0;
        dec_ill    = 1'b0;
        dec_is_md  = 1'b0;
        dec_is_div = 1'b0;
        // MUL/DIV encodings are parameters, so they are matched ahead of the
        // fixed table and take precedence if an override collides with it.
        if (ALUOp == MUL_OP) begin
            dec_op    = OP_MUL;
            dec_is_md = 1'b1;
        end else if (ALUOp == DIV_OP) begin
            dec_op     = OP_DIV;
            dec_is_md  = 1'b1;
            dec_is_div = 1'b1;
        end else begin
            case (ALUOp)
                5'b01000, 5'b10000, 5'b10001,
                5'b10011, 5'b00101: dec_op = OP_ADD;
                5'b11000: begin
                    dec_op  = OP_ADD;
                    dec_imm = 1'b1;
                end
                5'b11001: begin
                    dec_op   = OP_ADD;
                    dec_spec = SPEC_BTR;
                end
                5'b11111: begin
                    dec_op   = OP_ADD;
                    dec_spec = SPEC_SCO;
                end
                5'b10010: begin
                    dec_op   = OP_ADD;
                    dec_spec = SPEC_SLBI;
                end
                5'b01001: dec_op = OP_SUB;
                5'b01010: dec_op = OP_XOR;
                5'b01011: begin
                    dec_op   = OP_ANDN;
                    dec_invb = 1'b1;
                end
                5'b10100, 5'b10101,
                5'b10110, 5'b10111: dec_op = {2'b00, ALUOp[1:0]};
                5'b11100: begin
                    dec_op   = OP_CMP;
                    dec_spec = SPEC_SEQ;
                end
                5'b11101: begin
                    dec_op   = OP_CMP;
                    dec_spec = SPEC_SLT;
                end
                5'b11110: begin
                    dec_op   = OP_CMP;
                    dec_spec = SPEC_SLE;
                end
                5'b01100, 5'b01101,
                5'b01110, 5'b01111: dec_op = OP_CMP;
                5'b11011: begin
                    case (ALUF)
                        2'b00: dec_op = OP_ADD;
                        2'b01: dec_op = OP_SUB;
                        2'b10: dec_op = OP_XOR;
                        2'b11: begin
                            dec_op   = OP_ANDN;
                            dec_invb = 1'b1;
                        end
                        default: dec_op = OP_BAD;
                    endcase
                end
                5'b11010: dec_op = {2'b00, ALUF};
                default:  dec_ill = 1'b1;
            endcase
        end
    end

    // Stage can take a new op when empty, or when the held op drains this cycle
    always_comb begin
        in_ready = ~flush & ((state_q == S_IDLE) |
                             ((state_q == S_HOLD) & out_ready));
        accept   = in_valid & in_ready;
    end

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        op_d        = op_q;
        invb_d      = invb_q;
        imm_d       = imm_q;
        spec_d      = spec_q;
        ill_d       = ill_q;
        md_step_d   = md_step_q;
        md_first_d  = 1'b0;
        md_div_d    = md_div_q;

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            md_step_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        op_d     = dec_op;
                        invb_d   = dec_invb;
                        imm_d    = dec_imm;
                        spec_d   = dec_spec;
                        ill_d    = dec_ill;
                        md_div_d = dec_is_div;
                        if (dec_is_md) begin
                            state_d     = S_ITER;
                            cnt_d       = CW'(ITER_CYCLES);
                            out_valid_d = 1'b0;
                            md_step_d   = 1'b1;
                            md_first_d  = 1'b1;
                        end else begin
                            state_d     = S_HOLD;
                            out_valid_d = 1'b1;
                            md_step_d   = 1'b0;
                        end
                    end else if ((state_q == S_HOLD) && out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                S_ITER: begin
                    if (cnt_q == CW'(1)) begin
                        state_d     = S_HOLD;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        md_step_d   = 1'b0;
                    end else begin
                        cnt_d     = cnt_q - CW'(1);
                        md_step_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    md_step_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            invb_q      <= 1'b0;
            imm_q       <= 1'b0;
            spec_q      <= '0;
            ill_q       <= 1'b0;
            md_step_q   <= 1'b0;
            md_first_q  <= 1'b0;
            md_div_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            invb_q      <= invb_d;
            imm_q       <= imm_d;
            spec_q      <= spec_d;
            ill_q       <= ill_d;
            md_step_q   <= md_step_d;
            md_first_q  <= md_first_d;
            md_div_q    <= md_div_d;
        end
    end

    // Drive ports from registers
    always_comb begin
        out_valid = out_valid_q;
        opOut     = op_q;
        invB      = invb_q;
        immPass   = imm_q;
        spec_op   = spec_q;
        illegal   = ill_q;
        md_step   = md_step_q;
        md_first  = md_first_q;
        md_div    = md_div_q;
    end

endmodule
